// File: rtl/branch_comp_pkg.sv
// Shared RV32I B-type funct3 encodings, used by the branch comparator, decoder and ALU.
package branch_comp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 010 and 011 have no branch meaning in the B-type space.
  function automatic logic f3_reserved(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Operand comparator: equality, signed less-than and unsigned less-than.
module branch_cmp_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  always_comb begin
    eq  = (op1 == op2);
    lt  = ($signed(op1) < $signed(op2));
    ltu = (op1 < op2);
  end

endmodule

// File: rtl/branch_comp.sv
// EX-stage conditional-branch decision: combinational taken flag for PC select,
// plus a registered copy for pipeline/trace use.
module branch_comp
  import branch_comp_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      funct3,
  output logic            branch_taken,
  output logic            eq,
  output logic            lt,
  output logic            ltu,
  output logic            illegal_funct3,
  output logic            branch_taken_q
);

  branch_cmp_core #(
    .XLEN(XLEN)
  ) u_core (
    .op1 (op1),
    .op2 (op2),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  // Reserved and unknown funct3 values fall to the default: not taken.
  always_comb begin
    branch_taken   = 1'b0;
    illegal_funct3 = f3_reserved(funct3);
    case (funct3)
      F3_BEQ:  branch_taken = eq;
      F3_BNE:  branch_taken = !eq;
      F3_BLT:  branch_taken = lt;
      F3_BGE:  branch_taken = !lt;
      F3_BLTU: branch_taken = ltu;
      F3_BGEU: branch_taken = !ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_taken_q <= 1'b0;
    end else begin
      branch_taken_q <= branch_taken;
    end
  end

endmodule

// File: tb/tb_branch_comp.sv
// Scoreboard bench for branch_comp: directed spec cases plus randomized operands,
// checked against an arithmetic reference model.
module tb_branch_comp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [2:0]  funct3 = 3'b000;
  logic        branch_taken, eq, lt, ltu, illegal_funct3, branch_taken_q;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  typedef struct {
    string name;
    logic  taken;
    logic  eq;
    logic  lt;
    logic  ltu;
    logic  ill;
  } exp_t;

  exp_t sb_q[$];
  logic model_q = 1'b0;

  branch_comp #(
    .XLEN(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .op1            (op1),
    .op2            (op2),
    .funct3         (funct3),
    .branch_taken   (branch_taken),
    .eq             (eq),
    .lt             (lt),
    .ltu            (ltu),
    .illegal_funct3 (illegal_funct3),
    .branch_taken_q (branch_taken_q)
  );

  always #5 clk = ~clk;

  // Reference: operands widened to 64-bit signed/unsigned integers and compared directly.
  function automatic exp_t model(input string nm, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] f3);
    exp_t e;
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.name  = nm;
    e.eq    = (ua == ub);
    e.lt    = (sa < sb);
    e.ltu   = (ua < ub);
    e.ill   = (f3 == 3'd2) || (f3 == 3'd3);
    case (f3)
      3'd0:    e.taken = (ua == ub);
      3'd1:    e.taken = (ua != ub);
      3'd4:    e.taken = (sa < sb);
      3'd5:    e.taken = (sa >= sb);
      3'd6:    e.taken = (ua < ub);
      3'd7:    e.taken = (ua >= ub);
      default: e.taken = 1'b0;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  // Registered-path expectation: the decision present at each rising edge.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      model_q <= 1'b0;
    end else begin
      e = model("q", op1, op2, funct3);
      model_q <= e.taken;
    end
  end

  // Monitor: outputs are sampled on the falling edge, away from input changes.
  always @(negedge clk) begin
    exp_t e;
    chk("branch_taken_q", branch_taken_q, model_q);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.name, ".taken"}, branch_taken, e.taken);
      chk({e.name, ".eq"}, eq, e.eq);
      chk({e.name, ".lt"}, lt, e.lt);
      chk({e.name, ".ltu"}, ltu, e.ltu);
      chk({e.name, ".illegal"}, illegal_funct3, e.ill);
    end
  end

  task automatic apply(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3);
    @(posedge clk);
    #1;
    op1    = a;
    op2    = b;
    funct3 = f3;
    sb_q.push_back(model(nm, a, b, f3));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    // Release reset mid-cycle; the first edge afterwards loads the current decision.
    #12 rst = 1'b0;

    apply("beq_eq",     32'hA5A5A5A5, 32'hA5A5A5A5, 3'b000);
    apply("beq_ne",     32'hA5A5A5A5, 32'hB5B5B5B5, 3'b000);
    apply("bne_ne",     32'hA5A5A5A5, 32'hB6B6B6B6, 3'b001);
    apply("bne_eq",     32'hB6B6B6B6, 32'hB6B6B6B6, 3'b001);
    apply("blt_neg",    -32'sd10, -32'sd5, 3'b100);
    apply("blt_pos",    32'd2, -32'sd5, 3'b100);
    apply("bge_gt",     -32'sd5, -32'sd10, 3'b101);
    apply("bge_lt",     -32'sd20, -32'sd10, 3'b101);
    apply("bltu_lt",    32'd1, 32'hFFFFFFFF, 3'b110);
    apply("bltu_swap",  32'hFFFFFFFF, 32'd1, 3'b110);
    apply("bgeu_eq",    32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111);
    apply("bgeu_lt",    32'd1, 32'hFFFFFFFF, 3'b111);
    apply("bge_eq",     32'h1234_5678, 32'h1234_5678, 3'b101);
    apply("blt_eq",     32'h1234_5678, 32'h1234_5678, 3'b100);
    apply("bltu_eq",    32'h1234_5678, 32'h1234_5678, 3'b110);
    apply("f3_010",     32'h0000_0001, 32'h0000_0002, 3'b010);
    apply("f3_011",     32'h0000_0002, 32'h0000_0001, 3'b011);
    apply("f3_010_eq",  32'h0, 32'h0, 3'b010);
    apply("sign_blt",   32'h80000000, 32'h7FFFFFFF, 3'b100);
    apply("sign_bltu",  32'h80000000, 32'h7FFFFFFF, 3'b110);
    apply("ffff_blt",   32'hFFFFFFFF, 32'h00000001, 3'b100);
    apply("ffff_bltu",  32'hFFFFFFFF, 32'h00000001, 3'b110);

    for (int i = 0; i < 200; i++) begin
      a = pick_operand();
      b = ($urandom_range(0, 7) == 0) ? a : pick_operand();
      apply("rand", a, b, 3'($urandom_range(0, 7)));
    end

    // Asynchronous reset while the decision is 1, then release and reload.
    apply("rst_pre", 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b000);
    @(posedge clk);
    #7;
    chk("q_before_rst", branch_taken_q, 1'b1);
    rst = 1'b1;
    #1;
    chk("q_async_rst", branch_taken_q, 1'b0);
    @(posedge clk);
    #2;
    chk("q_held_in_rst", branch_taken_q, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("q_after_release", branch_taken_q, 1'b1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
